// File: rtl/board_judge.sv
// Tic-tac-toe board storage and referee: accepts controller cell writes, scans the
// eight winning lines one per cycle after each accepted move, and reports the result.
`timescale 1ns/1ps
module board_judge #(
    parameter int CELL_W = 2,
    parameter int ADDR_W = 4
) (
    input  logic              ph1,
    input  logic              ph2,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [CELL_W-1:0] cellState,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [CELL_W-1:0] rdData,
    output logic              gameIsDone,
    output logic [CELL_W-1:0] winner,
    output logic              draw,
    output logic              busy,
    output logic              illegalWrite,
    output logic [3:0]        filledCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CELL_W-1:0] EMPTY = 2'b00;
    localparam logic [ADDR_W-1:0] LAST_CELL = 4'd8;

    typedef struct packed {
        logic [8:0][CELL_W-1:0] board;
        logic [1:0]             state;
        logic [2:0]             lineIdx;
        logic [3:0]             filled;
        logic [CELL_W-1:0]      winner;
        logic                   draw;
        logic                   illegal;
    } judgeState_t;

    judgeState_t cur_r;
    judgeState_t mst_r;
    judgeState_t nxt_s;

    logic [11:0]       lineSel_s;
    logic [CELL_W-1:0] cellA_s;
    logic [CELL_W-1:0] cellB_s;
    logic [CELL_W-1:0] cellC_s;
    logic              lineWin_s;
    logic              writeReq_s;
    logic              addrOk_s;
    logic [3:0]        wrIdx_s;
    logic              writeOk_s;

    // Three cell addresses of winning line idx, packed {first, second, third}.
    function automatic logic [11:0] lineCells(input logic [2:0] idx);
        case (idx)
            3'd0:    lineCells = {4'd0, 4'd1, 4'd2};
            3'd1:    lineCells = {4'd3, 4'd4, 4'd5};
            3'd2:    lineCells = {4'd6, 4'd7, 4'd8};
            3'd3:    lineCells = {4'd0, 4'd3, 4'd6};
            3'd4:    lineCells = {4'd1, 4'd4, 4'd7};
            3'd5:    lineCells = {4'd2, 4'd5, 4'd8};
            3'd6:    lineCells = {4'd0, 4'd4, 4'd8};
            3'd7:    lineCells = {4'd2, 4'd4, 4'd6};
            default: lineCells = {4'd0, 4'd1, 4'd2};
        endcase
    endfunction

    assign lineSel_s  = lineCells(cur_r.lineIdx);
    assign cellA_s    = cur_r.board[lineSel_s[11:8]];
    assign cellB_s    = cur_r.board[lineSel_s[7:4]];
    assign cellC_s    = cur_r.board[lineSel_s[3:0]];
    assign lineWin_s  = (cellA_s == cellB_s) && (cellB_s == cellC_s) && cellA_s[1];

    // Out-of-range addresses are steered to cell 0 only so the lookup stays in bounds.
    assign writeReq_s = (cellState != EMPTY);
    assign addrOk_s   = (addr <= LAST_CELL);
    assign wrIdx_s    = addrOk_s ? addr[3:0] : 4'd0;
    assign writeOk_s  = cellState[1] && addrOk_s && (cur_r.board[wrIdx_s] == EMPTY);

    // Next-state logic: write capture, one-line-per-cycle scan, terminal result.
    always_comb begin
        nxt_s         = cur_r;
        nxt_s.illegal = 1'b0;
        if (!reset) begin
            nxt_s = '0;
        end else begin
            case (cur_r.state)
                IDLE: begin
                    if (writeReq_s) begin
                        if (writeOk_s) begin
                            nxt_s.board[wrIdx_s] = cellState;
                            nxt_s.filled         = cur_r.filled + 4'd1;
                            nxt_s.lineIdx        = 3'd0;
                            nxt_s.state          = SCAN;
                        end else begin
                            nxt_s.illegal = 1'b1;
                        end
                    end else begin
                        nxt_s.illegal = 1'b0;
                    end
                end
                SCAN: begin
                    nxt_s.illegal = writeReq_s;
                    if (lineWin_s) begin
                        nxt_s.state  = DONE;
                        nxt_s.winner = cellA_s;
                    end else if (cur_r.lineIdx != 3'd7) begin
                        nxt_s.lineIdx = cur_r.lineIdx + 3'd1;
                    end else if (cur_r.filled == 4'd9) begin
                        nxt_s.state = DONE;
                        nxt_s.draw  = 1'b1;
                    end else begin
                        nxt_s.state = IDLE;
                    end
                end
                DONE: begin
                    nxt_s.illegal = writeReq_s;
                end
                default: begin
                    nxt_s.state = IDLE;
                end
            endcase
        end
    end

    // Master stage captures the next state on ph2.
    always_ff @(posedge ph2) begin
        mst_r <= nxt_s;
    end

    // Slave stage makes the new state visible on ph1.
    always_ff @(posedge ph1) begin
        cur_r <= mst_r;
    end

    assign rdData       = (rdAddr <= LAST_CELL) ? cur_r.board[rdAddr[3:0]] : EMPTY;
    assign gameIsDone   = (cur_r.state == DONE);
    assign busy         = (cur_r.state == SCAN);
    assign winner       = cur_r.winner;
    assign draw         = cur_r.draw;
    assign illegalWrite = cur_r.illegal;
    assign filledCount  = cur_r.filled;

endmodule

// File: tb/tb_board_judge.sv
// Directed bench for board_judge: expectations are queued with a due cycle when
// stimulus is driven, then popped and compared when that cycle arrives.
`timescale 1ns/1ps
module tb_board_judge;

    logic       ph1, ph2, reset;
    logic [3:0] addr, rdAddr, filledCount;
    logic [1:0] cellState, rdData, winner;
    logic       gameIsDone, draw, busy, illegalWrite;

    localparam int SIG_BUSY = 0, SIG_DONE = 1, SIG_WIN = 2, SIG_DRAW = 3;
    localparam int SIG_ILL = 4, SIG_FILL = 5, SIG_RD = 6;
    localparam logic [1:0] X = 2'b10, O = 2'b11, E = 2'b00;

    typedef struct {
        int         due;
        int         sig;
        logic [3:0] val;
        logic [3:0] a;
        string      tag;
    } expEntry_t;

    expEntry_t sb[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    board_judge #(.CELL_W(2), .ADDR_W(4)) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset), .addr(addr), .cellState(cellState),
        .rdAddr(rdAddr), .rdData(rdData), .gameIsDone(gameIsDone), .winner(winner),
        .draw(draw), .busy(busy), .illegalWrite(illegalWrite), .filledCount(filledCount)
    );

    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #10 ph1 = 1'b1;
            #40 ph1 = 1'b0;
            #10 ph2 = 1'b1;
            #30 ph2 = 1'b0;
        end
    end

    function automatic logic [3:0] obsOf(input int sig);
        case (sig)
            SIG_BUSY: obsOf = {3'b000, busy};
            SIG_DONE: obsOf = {3'b000, gameIsDone};
            SIG_WIN:  obsOf = {2'b00, winner};
            SIG_DRAW: obsOf = {3'b000, draw};
            SIG_ILL:  obsOf = {3'b000, illegalWrite};
            SIG_FILL: obsOf = filledCount;
            SIG_RD:   obsOf = {2'b00, rdData};
            default:  obsOf = 4'hF;
        endcase
    endfunction

    task automatic expectAt(input int delta, input int sig, input logic [3:0] val, input string tag);
        sb.push_back('{cyc + delta, sig, val, 4'd0, tag});
    endtask

    task automatic expectRd(input int delta, input logic [3:0] a, input logic [1:0] val, input string tag);
        sb.push_back('{cyc + delta, SIG_RD, {2'b00, val}, a, tag});
    endtask

    task automatic checkDue();
        int i;
        logic [3:0] got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                if (sb[i].sig == SIG_RD) begin
                    rdAddr = sb[i].a;
                    #1;
                end
                got = obsOf(sb[i].sig);
                checks++;
                assert (got === sb[i].val) else begin
                    errors++;
                    $error("FAIL %s cycle %0d observed %0h expected %0h", sb[i].tag, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Advance one cycle, return inputs to idle, then check everything due now.
    task automatic tick();
        @(posedge ph1);
        #1;
        cyc++;
        reset = 1'b1;
        cellState = E;
        addr = 4'd0;
        checkDue();
    endtask

    task automatic waitN(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [3:0] a, input logic [1:0] v);
        addr = a;
        cellState = v;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        expectAt(1, SIG_BUSY, 4'd0, "rst_busy");
        expectAt(1, SIG_DONE, 4'd0, "rst_done");
        expectAt(1, SIG_WIN, 4'd0, "rst_winner");
        expectAt(1, SIG_DRAW, 4'd0, "rst_draw");
        expectAt(1, SIG_ILL, 4'd0, "rst_illegal");
        expectAt(1, SIG_FILL, 4'd0, "rst_filled");
        expectRd(1, 4'd0, E, "rst_cell0");
        expectRd(1, 4'd4, E, "rst_cell4");
        expectRd(1, 4'd8, E, "rst_cell8");
        tick();
    endtask

    // Accepted non-winning move: write, then wait until IDLE again.
    task automatic move(input logic [3:0] a, input logic [1:0] v);
        drive(a, v);
        waitN(9);
    endtask

    initial begin
        reset = 1'b0;
        cellState = E;
        addr = 4'd0;
        rdAddr = 4'd0;
        tick();
        applyReset();

        // X wins row 0 (line 0)
        move(4'd0, X); move(4'd3, O); move(4'd1, X); move(4'd4, O);
        drive(4'd2, X);
        expectAt(1, SIG_BUSY, 4'd1, "row0_busy_n1");
        expectAt(1, SIG_DONE, 4'd0, "row0_notdone_n1");
        expectAt(2, SIG_BUSY, 4'd0, "row0_busy_n2");
        expectAt(2, SIG_DONE, 4'd1, "row0_done");
        expectAt(2, SIG_WIN, {2'b00, X}, "row0_winner");
        expectAt(2, SIG_DRAW, 4'd0, "row0_draw");
        expectAt(2, SIG_FILL, 4'd5, "row0_filled");
        expectAt(4, SIG_WIN, {2'b00, X}, "row0_winner_hold");
        waitN(4);
        drive(4'd5, O);
        expectAt(1, SIG_ILL, 4'd1, "done_write_pulse");
        expectAt(2, SIG_ILL, 4'd0, "done_write_clear");
        expectAt(2, SIG_FILL, 4'd5, "done_write_filled");
        expectRd(2, 4'd5, E, "done_write_cell5");
        expectRd(2, 4'd10, E, "rd_out_of_range");
        expectAt(2, SIG_DONE, 4'd1, "done_hold");
        waitN(3);
        applyReset();

        // O wins anti-diagonal (line 7)
        move(4'd2, O); move(4'd0, X); move(4'd4, O); move(4'd1, X);
        drive(4'd6, O);
        expectAt(1, SIG_BUSY, 4'd1, "diag_busy_n1");
        expectAt(8, SIG_BUSY, 4'd1, "diag_busy_n8");
        expectAt(8, SIG_DONE, 4'd0, "diag_notdone_n8");
        expectAt(9, SIG_BUSY, 4'd0, "diag_busy_n9");
        expectAt(9, SIG_DONE, 4'd1, "diag_done");
        expectAt(9, SIG_WIN, {2'b00, O}, "diag_winner");
        expectAt(9, SIG_DRAW, 4'd0, "diag_draw");
        expectRd(9, 4'd4, O, "diag_cell4");
        waitN(10);
        applyReset();

        // Illegal writes in IDLE
        move(4'd4, X);
        drive(4'd4, O);
        expectAt(1, SIG_ILL, 4'd1, "occupied_pulse");
        expectAt(1, SIG_BUSY, 4'd0, "occupied_nobusy");
        expectAt(2, SIG_ILL, 4'd0, "occupied_clear");
        waitN(2);
        drive(4'd5, 2'b01);
        expectAt(1, SIG_ILL, 4'd1, "badval_pulse");
        expectAt(2, SIG_ILL, 4'd0, "badval_clear");
        waitN(2);
        drive(4'd12, X);
        expectAt(1, SIG_ILL, 4'd1, "badaddr_pulse");
        expectAt(1, SIG_BUSY, 4'd0, "badaddr_nobusy");
        expectAt(2, SIG_ILL, 4'd0, "badaddr_clear");
        expectAt(2, SIG_FILL, 4'd1, "illegal_filled");
        expectRd(2, 4'd4, X, "illegal_cell4");
        expectRd(2, 4'd5, E, "illegal_cell5");
        waitN(2);
        drive(4'd6, E);
        expectAt(1, SIG_ILL, 4'd0, "empty_noop");
        expectAt(1, SIG_BUSY, 4'd0, "empty_nobusy");
        waitN(2);
        applyReset();

        // Draw: X O X / X O O / O X X
        move(4'd0, X); move(4'd1, O); move(4'd2, X); move(4'd3, X);
        move(4'd4, O); move(4'd5, O); move(4'd6, O); move(4'd7, X);
        drive(4'd8, X);
        expectAt(8, SIG_BUSY, 4'd1, "draw_busy_n8");
        expectAt(9, SIG_DONE, 4'd1, "draw_done");
        expectAt(9, SIG_DRAW, 4'd1, "draw_flag");
        expectAt(9, SIG_WIN, 4'd0, "draw_winner");
        expectAt(9, SIG_FILL, 4'd9, "draw_filled");
        waitN(10);
        drive(4'd0, X);
        expectAt(1, SIG_ILL, 4'd1, "draw_write_pulse");
        expectAt(2, SIG_ILL, 4'd0, "draw_write_clear");
        expectRd(2, 4'd0, X, "draw_cell0");
        expectAt(2, SIG_FILL, 4'd9, "draw_write_filled");
        expectAt(2, SIG_DRAW, 4'd1, "draw_hold");
        waitN(2);
        applyReset();

        // Write during SCAN
        drive(4'd0, X);
        waitN(3);
        drive(4'd1, O);
        expectAt(1, SIG_ILL, 4'd1, "scan_write_pulse");
        expectAt(1, SIG_BUSY, 4'd1, "scan_busy");
        expectAt(5, SIG_BUSY, 4'd1, "scan_busy_n8");
        expectAt(6, SIG_BUSY, 4'd0, "scan_idle_n9");
        expectAt(6, SIG_FILL, 4'd1, "scan_filled");
        expectRd(6, 4'd1, E, "scan_cell1");
        waitN(6);
        drive(4'd1, O);
        expectAt(1, SIG_BUSY, 4'd1, "idle_accept_busy");
        expectAt(1, SIG_ILL, 4'd0, "idle_accept_noill");
        expectAt(1, SIG_FILL, 4'd2, "idle_accept_filled");
        waitN(9);
        applyReset();

        // Reset mid-scan
        drive(4'd8, X);
        waitN(3);
        reset = 1'b0;
        expectAt(1, SIG_BUSY, 4'd0, "midrst_busy");
        expectAt(1, SIG_FILL, 4'd0, "midrst_filled");
        expectAt(1, SIG_DONE, 4'd0, "midrst_done");
        expectRd(1, 4'd8, E, "midrst_cell8");
        waitN(2);
        drive(4'd8, X);
        expectAt(1, SIG_BUSY, 4'd1, "postrst_busy");
        expectAt(1, SIG_ILL, 4'd0, "postrst_noill");
        expectAt(1, SIG_FILL, 4'd1, "postrst_filled");
        expectRd(1, 4'd8, X, "postrst_cell8");
        waitN(10);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
